// File: rtl/ex_alu_pkg.sv
// Shared definitions for the EX-stage ALU/MDU: one-hot op bit positions,
// FSM state encoding and small helpers used by the datapath.
package ex_alu_pkg;

  localparam int ALU_OP_W = 20;

  localparam int OP_ADD   = 0;
  localparam int OP_SUB   = 1;
  localparam int OP_SLT   = 2;
  localparam int OP_SLTU  = 3;
  localparam int OP_AND   = 4;
  localparam int OP_NOR   = 5;
  localparam int OP_OR    = 6;
  localparam int OP_XOR   = 7;
  localparam int OP_SLL   = 8;
  localparam int OP_SRL   = 9;
  localparam int OP_SRA   = 10;
  localparam int OP_LUI   = 11;
  localparam int OP_MULT  = 12;
  localparam int OP_MULTU = 13;
  localparam int OP_DIV   = 14;
  localparam int OP_DIVU  = 15;
  localparam int OP_MFHI  = 16;
  localparam int OP_MFLO  = 17;
  localparam int OP_MTHI  = 18;
  localparam int OP_MTLO  = 19;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;

  typedef logic [ALU_OP_W-1:0] alu_op_t;

  // Exactly one bit set; anything else decodes as a no-op.
  function automatic logic op_is_onehot(input alu_op_t v);
    return (v != '0) && ((v & (v - ALU_OP_W'(1))) == '0);
  endfunction

  // Signed overflow from operand/result sign bits; sub flips the sign of b.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb,
                                   input logic r_msb, input logic sub);
    return (a_msb == (b_msb ^ sub)) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_mdu_iter.sv
// Iterative engine: shift-add multiplier (MUL_UNROLL bits per step) and
// restoring divider, both on magnitudes with a sign fix-up on the last step.
module alu_mdu_iter
  import ex_alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_UNROLL = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  localparam int W     = WIDTH;
  localparam int U     = MUL_UNROLL;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(WIDTH / MUL_UNROLL);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(WIDTH);

  logic             active_reg;
  logic             is_div_reg;
  logic             neg_q_reg;
  logic             neg_r_reg;
  logic             div_zero_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [W-1:0]     opnd_reg;
  logic [W-1:0]     src1_reg;
  logic [2*W-1:0]   prod_reg;
  logic [W-1:0]     rem_reg;
  logic [W-1:0]     quo_reg;

  logic             a_neg, b_neg;
  logic [W-1:0]     a_mag, b_mag;

  assign a_neg = is_signed & op_a[W-1];
  assign b_neg = is_signed & op_b[W-1];
  assign a_mag = a_neg ? -op_a : op_a;
  assign b_mag = b_neg ? -op_b : op_b;

  // Multiplier step: add multiplicand for each of the low U multiplier bits,
  // then shift the whole product register right by U.
  logic [W+U-1:0] pp [U+1];
  logic [2*W-1:0] prod_next;

  assign pp[0] = {{U{1'b0}}, prod_reg[2*W-1:W]};

  genvar gi;
  generate
    for (gi = 0; gi < U; gi++) begin : g_pp
      assign pp[gi+1] = pp[gi] +
                        (prod_reg[gi] ? ({{U{1'b0}}, opnd_reg} << gi) : '0);
    end
  endgenerate

  assign prod_next = {pp[U], prod_reg[W-1:U]};

  // Divider step: shift in next dividend bit, subtract if it fits.
  logic [W:0]   rem_shift;
  logic [W+1:0] rem_diff;
  logic         borrow;
  logic [W-1:0] rem_next;
  logic [W-1:0] quo_next;
  logic         unused_div_bits;

  assign rem_shift       = {rem_reg, quo_reg[W-1]};
  assign rem_diff        = {1'b0, rem_shift} - {2'b00, opnd_reg};
  assign borrow          = rem_diff[W+1];
  assign rem_next        = borrow ? rem_shift[W-1:0] : rem_diff[W-1:0];
  assign quo_next        = {quo_reg[W-2:0], ~borrow};
  assign unused_div_bits = ^{rem_shift[W], rem_diff[W]};

  assign done = active_reg & (cnt_reg == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      active_reg   <= 1'b0;
      is_div_reg   <= 1'b0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
      cnt_reg      <= '0;
      opnd_reg     <= '0;
      src1_reg     <= '0;
      prod_reg     <= '0;
      rem_reg      <= '0;
      quo_reg      <= '0;
    end else if (abort) begin
      active_reg <= 1'b0;
    end else if (start) begin
      active_reg   <= 1'b1;
      is_div_reg   <= is_div;
      neg_q_reg    <= a_neg ^ b_neg;
      neg_r_reg    <= a_neg;
      div_zero_reg <= (op_b == '0);
      cnt_reg      <= is_div ? DIV_CNT : MUL_CNT;
      opnd_reg     <= is_div ? b_mag : a_mag;
      src1_reg     <= op_a;
      prod_reg     <= {{W{1'b0}}, b_mag};
      rem_reg      <= '0;
      quo_reg      <= a_mag;
    end else if (active_reg) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
      if (done) begin
        active_reg <= 1'b0;
      end
      if (is_div_reg) begin
        rem_reg <= rem_next;
        quo_reg <= quo_next;
      end else begin
        prod_reg <= prod_next;
      end
    end
  end

  // Results are taken from the last step's next-state values so HI/LO can
  // be written on the same edge as the final iteration.
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix;
  logic [W-1:0]   rem_fix;

  assign prod_fix = neg_q_reg ? -prod_next : prod_next;
  assign quo_fix  = neg_q_reg ? -quo_next : quo_next;
  assign rem_fix  = neg_r_reg ? -rem_next : rem_next;

  always_comb begin
    res_hi = prod_fix[2*W-1:W];
    res_lo = prod_fix[W-1:0];
    if (is_div_reg) begin
      if (div_zero_reg) begin
        res_hi = src1_reg;
        res_lo = '1;
      end else begin
        res_hi = rem_fix;
        res_lo = quo_fix;
      end
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// EX-stage ALU with HI/LO and an iterative multiply/divide unit behind a
// valid/ready handshake; all results come out of one registered stage.
module alu_mdu
  import ex_alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_UNROLL = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALU_OP_W-1:0] alu_control,
  input  logic [WIDTH-1:0]    alu_src1,
  input  logic [WIDTH-1:0]    alu_src2,
  input  logic                flush,
  output logic                out_valid,
  output logic [WIDTH-1:0]    alu_result,
  output logic                overflow,
  output logic                busy
);

  localparam int SHW = $clog2(WIDTH);

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] alu_result_reg;
  logic             overflow_reg;

  logic             accept;
  logic             op_onehot;
  logic             start_mul;
  logic             start_div;
  logic             iter_done;
  logic [WIDTH-1:0] iter_hi;
  logic [WIDTH-1:0] iter_lo;

  assign busy      = (state_reg != ST_IDLE);
  assign in_ready  = (state_reg == ST_IDLE) & ~flush;
  assign accept    = in_valid & in_ready;
  assign op_onehot = op_is_onehot(alu_control);
  assign start_mul = accept & op_onehot &
                     (alu_control[OP_MULT] | alu_control[OP_MULTU]);
  assign start_div = accept & op_onehot &
                     (alu_control[OP_DIV] | alu_control[OP_DIVU]);

  assign out_valid  = out_valid_reg;
  assign alu_result = alu_result_reg;
  assign overflow   = overflow_reg;

  alu_mdu_iter #(
    .WIDTH      (WIDTH),
    .MUL_UNROLL (MUL_UNROLL)
  ) u_iter (
    .clk       (clk),
    .reset     (reset),
    .start     (start_mul | start_div),
    .abort     (flush & busy),
    .is_div    (alu_control[OP_DIV] | alu_control[OP_DIVU]),
    .is_signed (alu_control[OP_MULT] | alu_control[OP_DIV]),
    .op_a      (alu_src1),
    .op_b      (alu_src2),
    .done      (iter_done),
    .res_hi    (iter_hi),
    .res_lo    (iter_lo)
  );

  // Single-cycle datapath
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] dif;
  logic [WIDTH-1:0] alu_out;
  logic             alu_ovf;

  assign shamt = alu_src1[SHW-1:0];
  assign sum   = alu_src1 + alu_src2;
  assign dif   = alu_src1 - alu_src2;

  always_comb begin
    alu_out = '0;
    alu_ovf = 1'b0;
    if (op_onehot) begin
      if (alu_control[OP_ADD]) begin
        alu_out = sum;
        alu_ovf = add_ovf(alu_src1[WIDTH-1], alu_src2[WIDTH-1], sum[WIDTH-1], 1'b0);
      end else if (alu_control[OP_SUB]) begin
        alu_out = dif;
        alu_ovf = add_ovf(alu_src1[WIDTH-1], alu_src2[WIDTH-1], dif[WIDTH-1], 1'b1);
      end else if (alu_control[OP_SLT]) begin
        alu_out = WIDTH'($signed(alu_src1) < $signed(alu_src2));
      end else if (alu_control[OP_SLTU]) begin
        alu_out = WIDTH'(alu_src1 < alu_src2);
      end else if (alu_control[OP_AND]) begin
        alu_out = alu_src1 & alu_src2;
      end else if (alu_control[OP_NOR]) begin
        alu_out = ~(alu_src1 | alu_src2);
      end else if (alu_control[OP_OR]) begin
        alu_out = alu_src1 | alu_src2;
      end else if (alu_control[OP_XOR]) begin
        alu_out = alu_src1 ^ alu_src2;
      end else if (alu_control[OP_SLL]) begin
        alu_out = alu_src2 << shamt;
      end else if (alu_control[OP_SRL]) begin
        alu_out = alu_src2 >> shamt;
      end else if (alu_control[OP_SRA]) begin
        alu_out = $signed(alu_src2) >>> shamt;
      end else if (alu_control[OP_LUI]) begin
        alu_out = {alu_src2[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      end else if (alu_control[OP_MFHI]) begin
        alu_out = hi_reg;
      end else if (alu_control[OP_MFLO]) begin
        alu_out = lo_reg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      hi_reg         <= '0;
      lo_reg         <= '0;
      out_valid_reg  <= 1'b0;
      alu_result_reg <= '0;
      overflow_reg   <= 1'b0;
    end else begin
      out_valid_reg  <= 1'b0;
      alu_result_reg <= '0;
      overflow_reg   <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            if (start_mul) begin
              state_reg <= ST_MUL;
            end else if (start_div) begin
              state_reg <= ST_DIV;
            end else begin
              out_valid_reg  <= 1'b1;
              alu_result_reg <= alu_out;
              overflow_reg   <= alu_ovf;
              if (op_onehot && alu_control[OP_MTHI]) hi_reg <= alu_src1;
              if (op_onehot && alu_control[OP_MTLO]) lo_reg <= alu_src1;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          // A flush on the final iteration still wins over completion.
          if (flush) begin
            state_reg <= ST_IDLE;
          end else if (iter_done) begin
            state_reg     <= ST_IDLE;
            hi_reg        <= iter_hi;
            lo_reg        <= iter_lo;
            out_valid_reg <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Randomised bench for alu_mdu (WIDTH=32, MUL_UNROLL=2) against a
// behavioural model built on native SystemVerilog arithmetic.
module tb_alu_mdu;
  import ex_alu_pkg::*;

  localparam int W       = 32;
  localparam int UNR     = 2;
  localparam int MUL_LAT = W / UNR + 1;
  localparam int DIV_LAT = W + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [19:0]   alu_control;
  logic [W-1:0]  alu_src1;
  logic [W-1:0]  alu_src2;
  logic          flush;
  logic          out_valid;
  logic [W-1:0]  alu_result;
  logic          overflow;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] hi_m;
  logic [31:0] lo_m;

  always #5 clk = ~clk;

  alu_mdu #(.WIDTH(W), .MUL_UNROLL(UNR)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .alu_src1    (alu_src1),
    .alu_src2    (alu_src2),
    .flush       (flush),
    .out_valid   (out_valid),
    .alu_result  (alu_result),
    .overflow    (overflow),
    .busy        (busy)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] op_bit(input int i);
    logic [19:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFFFFFF;
      3:       return 32'h80000000;
      4:       return 32'h7FFFFFFF;
      5:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Reference: result, overflow, latency, and HI/LO effects of one op.
  task automatic ref_op(input logic [19:0] c, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic o, output int lat);
    longint s;
    logic [63:0] p;
    int idx;
    r   = '0;
    o   = 1'b0;
    lat = 1;
    if ($countones(c) == 1) begin
      idx = 0;
      for (int i = 0; i < 20; i++) if (c[i]) idx = i;
      case (idx)
        OP_ADD:  begin s = longint'($signed(a)) + longint'($signed(b)); r = s[31:0];
                       o = (s != longint'($signed(r))); end
        OP_SUB:  begin s = longint'($signed(a)) - longint'($signed(b)); r = s[31:0];
                       o = (s != longint'($signed(r))); end
        OP_SLT:  r = {31'b0, $signed(a) < $signed(b)};
        OP_SLTU: r = {31'b0, a < b};
        OP_AND:  r = a & b;
        OP_NOR:  r = ~(a | b);
        OP_OR:   r = a | b;
        OP_XOR:  r = a ^ b;
        OP_SLL:  r = b << a[4:0];
        OP_SRL:  r = b >> a[4:0];
        OP_SRA:  r = 32'($signed(b) >>> a[4:0]);
        OP_LUI:  r = {b[15:0], 16'h0000};
        OP_MULT: begin p = 64'(longint'($signed(a)) * longint'($signed(b)));
                       hi_m = p[63:32]; lo_m = p[31:0]; lat = MUL_LAT; end
        OP_MULTU: begin p = {32'b0, a} * {32'b0, b};
                        hi_m = p[63:32]; lo_m = p[31:0]; lat = MUL_LAT; end
        OP_DIV: begin
          lat = DIV_LAT;
          if (b == 0) begin lo_m = '1; hi_m = a; end
          else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin lo_m = a; hi_m = '0; end
          else begin lo_m = 32'($signed(a) / $signed(b)); hi_m = 32'($signed(a) % $signed(b)); end
        end
        OP_DIVU: begin
          lat = DIV_LAT;
          if (b == 0) begin lo_m = '1; hi_m = a; end
          else begin lo_m = a / b; hi_m = a % b; end
        end
        OP_MFHI: r = hi_m;
        OP_MFLO: r = lo_m;
        OP_MTHI: hi_m = a;
        OP_MTLO: lo_m = a;
        default: r = '0;
      endcase
    end
  endtask

  // Present one op at the current negedge, wait for out_valid, check it.
  task automatic run_op(input string tag, input logic [19:0] c,
                        input logic [31:0] a, input logic [31:0] b);
    logic [31:0] er;
    logic eo;
    int el, lat, busy_n, rdy_bad;
    bit got;
    ref_op(c, a, b, er, eo, el);
    in_valid = 1'b1; alu_control = c; alu_src1 = a; alu_src2 = b;
    #1;
    check_val($sformatf("%s.in_ready", tag), in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; alu_control = 20'($urandom); alu_src1 = $urandom; alu_src2 = $urandom;
    lat = 0; busy_n = 0; rdy_bad = 0; got = 0;
    while (!got && lat < 100) begin
      @(negedge clk);
      lat++;
      if (out_valid) got = 1;
      else begin
        if (busy) busy_n++;
        if (in_ready) rdy_bad++;
      end
    end
    check_val($sformatf("%s.latency", tag), lat, el);
    check_val($sformatf("%s.result", tag), alu_result, er);
    check_val($sformatf("%s.overflow", tag), overflow, eo);
    check_val($sformatf("%s.busy_cycles", tag), busy_n, el - 1);
    check_val($sformatf("%s.ready_while_busy", tag), rdy_bad, 0);
    check_val($sformatf("%s.busy_at_done", tag), busy, 0);
    $display("[%0t] %s ctrl=%h a=%h b=%h -> res=%h ovf=%0b lat=%0d", $time, tag, c, a, b,
             alu_result, overflow, lat);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen, k, i, j;
    logic [19:0] c;
    logic [31:0] a, b;

    reset = 1'b1; in_valid = 1'b0; flush = 1'b0;
    alu_control = '0; alu_src1 = '0; alu_src2 = '0;
    hi_m = '0; lo_m = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_val("reset.out_valid", out_valid, 0);
    check_val("reset.result", alu_result, 0);
    check_val("reset.overflow", overflow, 0);
    check_val("reset.busy", busy, 0);
    check_val("reset.in_ready", in_ready, 1);

    run_op("add_ovf", op_bit(OP_ADD), 32'h7FFFFFFF, 32'h1);
    run_op("sub_ovf", op_bit(OP_SUB), 32'h80000000, 32'h1);
    run_op("sra31", op_bit(OP_SRA), 32'h3F, 32'h80000000);
    run_op("lui", op_bit(OP_LUI), 32'h0, 32'h1234);
    run_op("slt", op_bit(OP_SLT), 32'hFFFFFFFF, 32'h1);
    run_op("sltu", op_bit(OP_SLTU), 32'hFFFFFFFF, 32'h1);
    run_op("mult", op_bit(OP_MULT), 32'hFFFFFFFE, 32'h3);
    run_op("mfhi_b2b", op_bit(OP_MFHI), 32'h0, 32'h0);
    run_op("mflo", op_bit(OP_MFLO), 32'h0, 32'h0);
    run_op("div_neg", op_bit(OP_DIV), 32'hFFFFFFF9, 32'h2);
    run_op("mflo", op_bit(OP_MFLO), 32'h0, 32'h0);
    run_op("mfhi", op_bit(OP_MFHI), 32'h0, 32'h0);
    run_op("divu_zero", op_bit(OP_DIVU), 32'h7, 32'h0);
    run_op("mflo", op_bit(OP_MFLO), 32'h0, 32'h0);
    run_op("mfhi", op_bit(OP_MFHI), 32'h0, 32'h0);
    run_op("div_minneg", op_bit(OP_DIV), 32'h80000000, 32'hFFFFFFFF);
    run_op("mflo", op_bit(OP_MFLO), 32'h0, 32'h0);
    run_op("mfhi", op_bit(OP_MFHI), 32'h0, 32'h0);
    run_op("noop_zero", 20'h0, 32'h5, 32'h6);
    run_op("noop_multi", op_bit(OP_ADD) | op_bit(OP_MTHI), 32'h1, 32'h2);
    run_op("mfhi_after_noop", op_bit(OP_MFHI), 32'h0, 32'h0);

    // Flush while idle: the offered mthi must be dropped.
    flush = 1'b1; in_valid = 1'b1; alu_control = op_bit(OP_MTHI);
    alu_src1 = 32'hDEAD0001; alu_src2 = '0;
    #1 check_val("flush_idle.in_ready", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_val("flush_idle.out_valid", out_valid, 0);
    run_op("mfhi_after_flush", op_bit(OP_MFHI), 32'h0, 32'h0);

    // Flush a divide in flight at N+5.
    run_op("mtlo5", op_bit(OP_MTLO), 32'h5, 32'h0);
    in_valid = 1'b1; alu_control = op_bit(OP_DIV); alu_src1 = 32'd100; alu_src2 = 32'd7;
    @(posedge clk); #1 in_valid = 1'b0;
    seen = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check_val("flush_div.busy", busy, 0);
    check_val("flush_div.in_ready", in_ready, 1);
    for (int n = 0; n < 40; n++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    check_val("flush_div.no_out_valid", seen, 0);
    run_op("mflo_after_flush", op_bit(OP_MFLO), 32'h0, 32'h0);
    run_op("mfhi_after_flush", op_bit(OP_MFHI), 32'h0, 32'h0);

    // Reset at N+10 of a multu.
    run_op("mthi", op_bit(OP_MTHI), 32'h1234ABCD, 32'h0);
    in_valid = 1'b1; alu_control = op_bit(OP_MULTU);
    alu_src1 = 32'hDEADBEEF; alu_src2 = 32'h12345678;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    hi_m = '0; lo_m = '0;
    @(negedge clk);
    check_val("reset_mdu.busy", busy, 0);
    check_val("reset_mdu.in_ready", in_ready, 1);
    seen = 0;
    for (int n = 0; n < 30; n++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    check_val("reset_mdu.no_out_valid", seen, 0);
    run_op("mfhi_after_reset", op_bit(OP_MFHI), 32'h0, 32'h0);
    run_op("mflo_after_reset", op_bit(OP_MFLO), 32'h0, 32'h0);

    // Random traffic; every multiply/divide is followed by HI and LO reads.
    for (int t = 0; t < 200; t++) begin
      k = $urandom_range(0, 21);
      if (k < 20) c = op_bit(k);
      else if (k == 20) c = '0;
      else begin
        i = $urandom_range(0, 19);
        j = (i + 1 + $urandom_range(0, 18)) % 20;
        c = op_bit(i) | op_bit(j);
      end
      a = pick();
      b = pick();
      run_op($sformatf("rnd%0d", t), c, a, b);
      if (k >= OP_MULT && k <= OP_DIVU) begin
        run_op($sformatf("rnd%0d_mfhi", t), op_bit(OP_MFHI), 32'h0, 32'h0);
        run_op($sformatf("rnd%0d_mflo", t), op_bit(OP_MFLO), 32'h0, 32'h0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
